morse_rx_core: RTL and testbench

MORSE_RX_CORE -- requirements
Module: morse_rx_core

---
 rtl/morse_rx_core.sv | 238 +++++++++++++++++++++++
 tb/tb_morse_rx_core.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_rx_core.sv
// Morse key receiver: synchronise and debounce the key, classify presses into dots/dashes,
// decode characters into a small FIFO, and drain that FIFO on request.
module morse_rx_core #(
  parameter int MAX_SYM  = 5,
  parameter int DEPTH    = 8,
  parameter int DEB_CYC  = 1000000,
  parameter int DOT_MAX  = 25000000,
  parameter int CHAR_GAP = 50000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         key,
  input  logic                         bksp,
  input  logic                         send,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [5:0]                   out_char,
  output logic [MAX_SYM-1:0]           sym_bits,
  output logic [$clog2(MAX_SYM+1)-1:0] sym_cnt,
  output logic [6*DEPTH-1:0]           buf_flat,
  output logic [$clog2(DEPTH+1)-1:0]   buf_cnt,
  output logic                         err_len,
  output logic                         err_char,
  output logic                         err_full
);

  localparam int SCW  = $clog2(MAX_SYM + 1);
  localparam int BCW  = $clog2(DEPTH + 1);
  localparam int PW   = $clog2(DEPTH);
  localparam int DW   = $clog2(DEB_CYC + 1);
  localparam int TMAX = (DOT_MAX + 1 > CHAR_GAP) ? DOT_MAX + 1 : CHAR_GAP;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, PRESS, GAP, DRAIN} state_t;

  state_t          state;
  logic            key_meta, key_sync, deb, deb_d;
  logic [DW-1:0]   deb_cnt;
  logic [TW-1:0]   timer;
  logic [5:0]      mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr, waddr;
  logic            push_pend;
  logic [5:0]      push_code;

  logic       rise, fall, send_ok, bksp_ok, bk_sym, bk_buf, pop;
  logic       sym_add, dash, gap_done, commit, dec_ok, commit_push;
  logic [5:0] dec_code;

  // {symbol count, pattern} -> {valid, code}; first symbol sits in the highest used bit
  function automatic logic [6:0] decode(input logic [2:0] n, input logic [5:0] p);
    case ({n, p})
      9'b010_000001: decode = {1'b1, 6'd0};
      9'b100_001000: decode = {1'b1, 6'd1};
      9'b100_001010: decode = {1'b1, 6'd2};
      9'b011_000100: decode = {1'b1, 6'd3};
      9'b001_000000: decode = {1'b1, 6'd4};
      9'b100_000010: decode = {1'b1, 6'd5};
      9'b011_000110: decode = {1'b1, 6'd6};
      9'b100_000000: decode = {1'b1, 6'd7};
      9'b010_000000: decode = {1'b1, 6'd8};
      9'b100_000111: decode = {1'b1, 6'd9};
      9'b011_000101: decode = {1'b1, 6'd10};
      9'b100_000100: decode = {1'b1, 6'd11};
      9'b010_000011: decode = {1'b1, 6'd12};
      9'b010_000010: decode = {1'b1, 6'd13};
      9'b011_000111: decode = {1'b1, 6'd14};
      9'b100_000110: decode = {1'b1, 6'd15};
      9'b100_001101: decode = {1'b1, 6'd16};
      9'b011_000010: decode = {1'b1, 6'd17};
      9'b011_000000: decode = {1'b1, 6'd18};
      9'b001_000001: decode = {1'b1, 6'd19};
      9'b011_000001: decode = {1'b1, 6'd20};
      9'b100_000001: decode = {1'b1, 6'd21};
      9'b011_000011: decode = {1'b1, 6'd22};
      9'b100_001001: decode = {1'b1, 6'd23};
      9'b100_001011: decode = {1'b1, 6'd24};
      9'b100_001100: decode = {1'b1, 6'd25};
      9'b101_011111: decode = {1'b1, 6'd26};
      9'b101_001111: decode = {1'b1, 6'd27};
      9'b101_000111: decode = {1'b1, 6'd28};
      9'b101_000011: decode = {1'b1, 6'd29};
      9'b101_000001: decode = {1'b1, 6'd30};
      9'b101_000000: decode = {1'b1, 6'd31};
      9'b101_010000: decode = {1'b1, 6'd32};
      9'b101_011000: decode = {1'b1, 6'd33};
      9'b101_011100: decode = {1'b1, 6'd34};
      9'b101_011110: decode = {1'b1, 6'd35};
      default:       decode = 7'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      key_meta <= 1'b0;
      key_sync <= 1'b0;
      deb      <= 1'b0;
      deb_d    <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      key_meta <= key;
      key_sync <= key_meta;
      deb_d    <= deb;
      if (key_sync == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEB_CYC - 1)) begin
        deb     <= key_sync;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  always_comb begin
    rise        = deb & ~deb_d;
    fall        = ~deb & deb_d;
    send_ok     = send && (state == IDLE) && (buf_cnt != '0);
    // an accepted send wins over a simultaneous backspace so DRAIN never starts empty
    bksp_ok     = bksp && ((state == IDLE) || (state == GAP)) && !send_ok;
    bk_sym      = bksp_ok && (sym_cnt != '0);
    bk_buf      = bksp_ok && (sym_cnt == '0) && (buf_cnt != '0);
    pop         = (state == DRAIN) && out_ready;
    sym_add     = (state == PRESS) && fall;
    dash        = timer > TW'(DOT_MAX);
    gap_done    = (state == GAP) && !rise && (timer == TW'(CHAR_GAP - 1));
    commit      = gap_done && (sym_cnt != '0);
    {dec_ok, dec_code} = decode(3'(sym_cnt), 6'(sym_bits));
    commit_push = commit && dec_ok && (buf_cnt != BCW'(DEPTH));
    waddr       = bk_buf ? wr_ptr - PW'(1) : wr_ptr;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      timer     <= '0;
      sym_bits  <= '0;
      sym_cnt   <= '0;
      push_pend <= 1'b0;
      push_code <= '0;
      err_len   <= 1'b0;
      err_char  <= 1'b0;
      err_full  <= 1'b0;
    end else begin
      push_pend <= commit_push;
      if (commit_push) push_code <= dec_code;

      case (state)
        IDLE: begin
          if (send_ok) begin
            state <= DRAIN;
          end else if (rise) begin
            state <= PRESS;
            timer <= '0;
          end
        end
        PRESS: begin
          if (fall) begin
            state <= GAP;
            timer <= '0;
          end else if (timer != '1) begin
            timer <= timer + TW'(1);
          end
        end
        GAP: begin
          if (rise) begin
            state <= PRESS;
            timer <= '0;
          end else if (gap_done) begin
            state <= IDLE;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DRAIN: if (pop && buf_cnt == BCW'(1)) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (gap_done) begin
        sym_bits <= '0;
        sym_cnt  <= '0;
      end else if (sym_add && sym_cnt != SCW'(MAX_SYM)) begin
        sym_bits <= (sym_bits << 1) | MAX_SYM'(dash);
        sym_cnt  <= sym_cnt + SCW'(1);
      end else if (bk_sym) begin
        sym_bits <= sym_bits >> 1;
        sym_cnt  <= sym_cnt - SCW'(1);
      end

      if (send_ok) begin
        err_len  <= 1'b0;
        err_char <= 1'b0;
        err_full <= 1'b0;
      end else begin
        if (sym_add && sym_cnt == SCW'(MAX_SYM)) err_len <= 1'b1;
        if (commit && !dec_ok) err_char <= 1'b1;
        if (commit && dec_ok && buf_cnt == BCW'(DEPTH)) err_full <= 1'b1;
      end
    end
  end

  // a push and a buffer backspace in the same cycle replace the newest entry
  always_ff @(posedge clk) begin
    if (push_pend) mem[waddr] <= push_code;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      buf_cnt <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push_pend, bk_buf})
        2'b10:   wr_ptr <= wr_ptr + PW'(1);
        2'b01:   wr_ptr <= wr_ptr - PW'(1);
        default: wr_ptr <= wr_ptr;
      endcase
      case ({push_pend, bk_buf, pop})
        3'b100:         buf_cnt <= buf_cnt + BCW'(1);
        3'b010, 3'b001: buf_cnt <= buf_cnt - BCW'(1);
        default:        buf_cnt <= buf_cnt;
      endcase
    end
  end

  always_comb begin
    out_valid = (state == DRAIN);
    out_char  = out_valid ? mem[rd_ptr] : 6'd63;
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign buf_flat[6*gi +: 6] = (BCW'(gi) < buf_cnt) ? mem[rd_ptr + PW'(gi)] : 6'd63;
    end
  endgenerate

endmodule

// File: tb/tb_morse_rx_core.sv
// Randomised bench for morse_rx_core: a string-level Morse model predicts the buffer,
// and a monitor scoreboard checks every drained character.
module tb_morse_rx_core;
  localparam int MAX_SYM  = 5;
  localparam int DEPTH    = 4;
  localparam int DEB_CYC  = 4;
  localparam int DOT_MAX  = 20;
  localparam int CHAR_GAP = 40;

  logic clk = 1'b0;
  logic rst = 1'b0, key = 1'b0, bksp = 1'b0, send = 1'b0, out_ready = 1'b0;
  logic        out_valid;
  logic [5:0]  out_char;
  logic [4:0]  sym_bits;
  logic [2:0]  sym_cnt;
  logic [23:0] buf_flat;
  logic [2:0]  buf_cnt;
  logic        err_len, err_char, err_full;

  morse_rx_core #(.MAX_SYM(MAX_SYM), .DEPTH(DEPTH), .DEB_CYC(DEB_CYC),
                  .DOT_MAX(DOT_MAX), .CHAR_GAP(CHAR_GAP)) dut (
    .clk(clk), .rst(rst), .key(key), .bksp(bksp), .send(send), .out_ready(out_ready),
    .out_valid(out_valid), .out_char(out_char), .sym_bits(sym_bits), .sym_cnt(sym_cnt),
    .buf_flat(buf_flat), .buf_cnt(buf_cnt),
    .err_len(err_len), .err_char(err_char), .err_full(err_full));

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  string morse[36];
  int    model_q[$];
  int    exp_q[$];
  bit    m_len, m_char, m_full;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // scoreboard monitor: every handshake pops one expected character
  initial begin : monitor
    int e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL drain_extra actual=%0d expected=none", out_char);
        end else begin
          e = exp_q.pop_front();
          $display("pop char=%0d expect=%0d", out_char, e);
          chk("drain_char", 64'(out_char), 64'(e));
        end
      end
    end
  end

  function automatic void model_commit(input string pat);
    string p;
    int found;
    p = pat;
    found = -1;
    if (p.len() > MAX_SYM) begin
      m_len = 1'b1;
      p = p.substr(0, MAX_SYM - 1);
    end
    if (p.len() == 0) return;
    for (int i = 0; i < 36; i++) if (morse[i] == p) found = i;
    if (found < 0) m_char = 1'b1;
    else if (model_q.size() == DEPTH) m_full = 1'b1;
    else model_q.push_back(found);
  endfunction

  task automatic check_model(input string tag);
    logic [23:0] f;
    f = '1;
    for (int i = 0; i < model_q.size(); i++) f[6*i +: 6] = 6'(model_q[i]);
    chk({tag, ".buf_cnt"}, 64'(buf_cnt), 64'(model_q.size()));
    chk({tag, ".buf_flat"}, 64'(buf_flat), 64'(f));
    chk({tag, ".sym_cnt"}, 64'(sym_cnt), 64'd0);
    chk({tag, ".err"}, {61'd0, err_len, err_char, err_full}, {61'd0, m_len, m_char, m_full});
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".out_char"}, 64'(out_char), 64'd63);
    chk({tag, ".buf_cnt"}, 64'(buf_cnt), 64'd0);
    chk({tag, ".buf_flat"}, 64'(buf_flat), 64'hFFFFFF);
    chk({tag, ".sym_cnt"}, 64'(sym_cnt), 64'd0);
    chk({tag, ".sym_bits"}, 64'(sym_bits), 64'd0);
    chk({tag, ".err"}, {61'd0, err_len, err_char, err_full}, 64'd0);
  endtask

  // key one character; press lengths stay well clear of the dot/dash threshold
  task automatic key_char(input string pat);
    for (int i = 0; i < pat.len(); i++) begin
      key = 1'b1;
      cyc(pat[i] == 8'h2D ? int'($urandom_range(28, 36)) : int'($urandom_range(6, 12)));
      key = 1'b0;
      cyc(i == pat.len() - 1 ? 60 : int'($urandom_range(8, 18)));
    end
    model_commit(pat);
    $display("char '%s' buf_cnt=%0d", pat, buf_cnt);
    check_model({"char_", pat});
  endtask

  task automatic start_send();
    send = 1'b1;
    if (model_q.size() > 0) begin
      foreach (model_q[i]) exp_q.push_back(model_q[i]);
      model_q.delete();
      m_len = 1'b0; m_char = 1'b0; m_full = 1'b0;
    end
  endtask

  task automatic drain(input bit always_ready);
    int n, k;
    k = model_q.size();
    start_send();
    out_ready = always_ready ? 1'b1 : 1'($urandom_range(0, 1));
    cyc(1);
    send = 1'b0;
    n = 0;
    while (out_valid === 1'b1 && n < 300) begin
      n++;
      if (!always_ready) out_ready = 1'($urandom_range(0, 1));
      cyc(1);
    end
    out_ready = 1'b0;
    chk("drain_end_valid", 64'(out_valid), 64'd0);
    chk("drain_end_char", 64'(out_char), 64'd63);
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    if (always_ready) chk("drain_cycles", 64'(n), 64'(k));
    exp_q.delete();
    check_model("after_send");
  endtask

  initial begin
    #5000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    morse = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
              "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
              "..-", "...-", ".--", "-..-", "-.--", "--..",
              "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
              "---..", "----."};
    m_len = 1'b0; m_char = 1'b0; m_full = 1'b0;

    rst = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(1);
    check_reset("reset");

    // press 10, release 10, press 30, release -> "A"
    key = 1'b1; cyc(10); key = 1'b0; cyc(10);
    key = 1'b1; cyc(30); key = 1'b0; cyc(60);
    model_commit(".-");
    check_model("fixed_A");
    chk("fixed_A.entry0", 64'(buf_flat[5:0]), 64'd0);
    drain(1'b1);

    repeat (3) begin
      n = $urandom_range(1, 4);
      repeat (n) key_char(morse[$urandom_range(0, 35)]);
      drain(1'b0);
    end

    // too many symbols, then an undecodable pattern; send clears both flags
    key_char("......");
    key_char("..--");
    drain(1'b1);

    // overflow the buffer with E
    repeat (5) key_char(".");
    drain(1'b1);

    // backspace: pending symbol, then buffer entry, then nothing
    key_char(".-");
    key = 1'b1; cyc(30); key = 1'b0; cyc(15);
    chk("bksp.pending_cnt", 64'(sym_cnt), 64'd1);
    chk("bksp.pending_bits", 64'(sym_bits), 64'd1);
    bksp = 1'b1; cyc(1); bksp = 1'b0; cyc(2);
    chk("bksp1.sym_cnt", 64'(sym_cnt), 64'd0);
    chk("bksp1.buf_cnt", 64'(buf_cnt), 64'd1);
    bksp = 1'b1; cyc(1); bksp = 1'b0; cyc(2);
    chk("bksp2.buf_cnt", 64'(buf_cnt), 64'd0);
    bksp = 1'b1; cyc(1); bksp = 1'b0; cyc(2);
    chk("bksp3.buf_cnt", 64'(buf_cnt), 64'd0);
    chk("bksp3.sym_cnt", 64'(sym_cnt), 64'd0);
    cyc(60);
    model_q.delete();
    check_model("bksp_done");

    // 3-cycle bounces must not register; a real dash afterwards decodes as T
    repeat (5) begin
      key = 1'b1; cyc(3); key = 1'b0; cyc(3);
    end
    cyc(60);
    check_model("bounce");
    key_char("-");

    // drain with ready toggling, then reset mid-drain
    key_char(morse[$urandom_range(0, 35)]);
    key_char(morse[$urandom_range(0, 35)]);
    start_send();
    out_ready = 1'b0;
    cyc(1);
    send = 1'b0;
    for (int i = 0; i < 4; i++) begin
      out_ready = (i % 2 == 0);
      cyc(1);
    end
    out_ready = 1'b0;
    chk("toggle.pops_left", 64'(exp_q.size()), 64'd1);
    chk("toggle.still_valid", 64'(out_valid), 64'd1);
    rst = 1'b0;
    cyc(1);
    check_reset("mid_drain_reset");
    rst = 1'b1;
    exp_q.delete();
    model_q.delete();
    m_len = 1'b0; m_char = 1'b0; m_full = 1'b0;
    cyc(2);

    key_char(morse[$urandom_range(0, 35)]);
    drain(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
